jk_stim_sequencer: RTL and testbench
====================================

// Module: jk_stim_sequencer
// PURPOSE
//  Sequences the 3-bit JK state machine (single-bit x in, F and S[2:0] out) through a programmed
//  serial input pattern, LSB first, one bit per clock. Resets the machine, captures F after every
//  applied bit plus the final S, and compares the captured F stream against an expected pattern.
//  Sits between the machine and a host/bench controller; owns the machine's x and reset inputs.
// PARAMETERS
//  MAX_LEN  16                  max pattern length in bits
//  LEN_W    $clog2(MAX_LEN+1)   width of length field
//  S_W      3                   machine state width
// PORTS
//  CLK        in   1        single clock, all logic on rising edge
//  RESET      in   1        synchronous, active-high reset
//  start      in   1        request a run; accepted only in IDLE
//  abort      in   1        cancel run in progress
//  pattern    in   MAX_LEN  x bits, pattern[0] applied first
//  expect_f   in   MAX_LEN  expected F after each bit
//  len        in   LEN_W    bits to apply; values >MAX_LEN clamp to MAX_LEN
//  x_out      out  1        drives machine x
//  m_reset    out  1        drives machine RESET
//  f_in       in   1        machine F
//  s_in       in   S_W      machine S
//  busy       out  1        high in LOAD/RUN/DRAIN
//  done       out  1        one-cycle pulse in DONE
//  f_capture  out  MAX_LEN  captured F; bit k = F after pattern[k] clocked in
//  s_final    out  S_W      S sampled in DRAIN
//  f_ones     out  LEN_W    popcount of f_capture
//  pass       out  1        (f_capture ^ expect_f) & lenmask == 0
// BEHAVIOUR
//  Reset: state=IDLE; x_out=0, m_reset=0, busy=0, done=0, f_capture=0, s_final=0, f_ones=0, pass=0.
//  FSM: IDLE -start-> LOAD (1 cyc) -> RUN (len cyc) -> DRAIN (1 cyc) -> DONE (1 cyc) -> IDLE.
//  LOAD: latch pattern/expect_f/clamped len; m_reset=1; x_out=0; clear f_capture,f_ones,pass,s_final.
//  RUN cycle k (k=0..len-1): x_out=pattern[k]; m_reset=0; for k>=1 capture f_in into f_capture[k-1].
//  DRAIN: x_out=0; f_capture[len-1]<=f_in; s_final<=s_in.
//  DONE: done=1; f_ones, pass registered from final f_capture; results hold until next LOAD.
//  Latency start->done pulse = len+3 cycles (start seen in IDLE, done in cycle len+3 after).
//  len==0: LOAD -> DONE directly; f_capture=0, f_ones=0, pass=1, s_final=0.
//  start while busy or in DONE: ignored. start and abort same cycle in IDLE: start wins.
//  abort in LOAD/RUN/DRAIN: next state IDLE, x_out=0, no done pulse, partial results retained,
//    pass forced 0. abort in IDLE/DONE: no effect.
//  RESET mid-run: all outputs to reset values next edge; machine not re-reset until next LOAD.
//  Bit index counter wraps never: saturates at len-1 exit condition; width LEN_W.
//  pass compares only bits [len-1:0]; upper bits masked.
// STRUCTURE
//  jk_seq_defs.vh: state encodings (IDLE,LOAD,RUN,DRAIN,DONE, 3-bit), MAX_LEN default.
//  One sub-module: jk_popcount (combinational, MAX_LEN in, LEN_W out) feeding f_ones register.
//  FSM, bit counter, capture shift/index register in top.
// TESTING  (bench stub machine: on CLK, q<=m_reset?0:x; f_in=q; s_in = last 3 x bits, reset 0)
//  1. RESET=1 2 cyc -> all outputs 0, busy=0; x_out=0.
//  2. len=4, pattern=4'b1011, expect_f=4'b1011 -> done at start+7, f_capture=0x000B, f_ones=3,
//     pass=1, s_final=3'b101, x_out seq 1,1,0,1.
//  3. len=4, pattern=4'b1011, expect_f=4'b0011 -> pass=0, f_ones=3.
//  4. len=0 -> done at start+2, pass=1, f_capture=0; len=20 -> clamped, 16 bits applied, done at +19.
//  5. abort in RUN cycle 2 of len=8 -> IDLE next cycle, busy=0, no done, pass=0; start during
//     busy ignored (no second LOAD observed).
//  6. RESET asserted mid-RUN -> outputs zero next edge; fresh start then completes normally.

Source files
------------

// File: rtl/jk_stim_sequencer_pkg.sv
// rtl/jk_stim_sequencer_pkg.sv - shared state encoding and defaults for the JK stimulus sequencer
// Purpose: sequencer FSM state type and default sizing used by the top and the bench.
// Ports: none (package).
package jk_stim_sequencer_pkg;

    localparam int MAX_LEN_DEF = 16;
    localparam int S_W_DEF     = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/jk_popcount.sv
// rtl/jk_popcount.sv - combinational population count
// Purpose: counts the set bits of a vector.
// Ports:
//   vec   in   N   vector to count
//   count out  W   number of ones in vec
module jk_popcount #(
    parameter int N = 16,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + W'(vec[i]);
        end
    end

endmodule

// File: rtl/jk_stim_sequencer.sv
// rtl/jk_stim_sequencer.sv - drives a JK state machine through a serial pattern and checks its F stream
// Purpose: resets the machine, shifts pattern bits into x (LSB first), captures F after each bit
//          and the final S, then reports popcount and pass/fail against an expected F pattern.
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   start, abort          run request (IDLE only) / cancel of a run in progress
//   pattern, expect_f     x bits to apply and expected F after each bit
//   len                   number of bits to apply (clamped to MAX_LEN)
//   x_out, m_reset        machine x and machine reset
//   f_in, s_in            machine F and S
//   busy, done            run in progress / one-cycle completion pulse
//   f_capture, s_final    captured F stream and final machine state
//   f_ones, pass          popcount of captured F, masked compare result
module jk_stim_sequencer
    import jk_stim_sequencer_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int S_W     = S_W_DEF
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               start,
    input  logic               abort,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [MAX_LEN-1:0] expect_f,
    input  logic [LEN_W-1:0]   len,
    output logic               x_out,
    output logic               m_reset,
    input  logic               f_in,
    input  logic [S_W-1:0]     s_in,
    output logic               busy,
    output logic               done,
    output logic [MAX_LEN-1:0] f_capture,
    output logic [S_W-1:0]     s_final,
    output logic [LEN_W-1:0]   f_ones,
    output logic               pass
);

    seq_state_t          state, state_nxt;
    logic [MAX_LEN-1:0]  pattern_r, expect_r;
    logic [LEN_W-1:0]    len_r, idx, len_clamped, cap_pos, ones_next;
    logic [MAX_LEN-1:0]  cap_next, len_mask;
    logic                cap_en, pass_next, last_bit;

    assign len_clamped = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    assign last_bit    = (idx == len_r - LEN_W'(1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        x_out     = 1'b0;
        m_reset   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                busy    = 1'b1;
                m_reset = 1'b1;
                if (abort)             state_nxt = ST_IDLE;
                else if (len_r == '0)  state_nxt = ST_DONE;
                else                   state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (LEN_W'(i) == idx) x_out = pattern_r[i];
                end
                if (abort)         state_nxt = ST_IDLE;
                else if (last_bit) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy      = 1'b1;
                state_nxt = abort ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // F lags x by one clock: in RUN cycle k the machine shows F for bit k-1,
    // and the last bit's F only appears in DRAIN.
    always_comb begin
        cap_en   = ((state == ST_RUN) && (idx != '0)) || (state == ST_DRAIN);
        cap_pos  = (state == ST_DRAIN) ? len_r : idx;
        cap_next = f_capture;
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (cap_en && (cap_pos == LEN_W'(i + 1))) cap_next[i] = f_in;
            len_mask[i] = (LEN_W'(i) < len_r);
        end
        pass_next = ~|((cap_next ^ expect_r) & len_mask);
    end

    jk_popcount #(
        .N (MAX_LEN),
        .W (LEN_W)
    ) u_popcount (
        .vec   (cap_next),
        .count (ones_next)
    );

    // Results are registered on the edge entering DONE so they are valid alongside the done pulse.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pattern_r <= '0;
            expect_r  <= '0;
            len_r     <= '0;
            idx       <= '0;
            f_capture <= '0;
            s_final   <= '0;
            f_ones    <= '0;
            pass      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pattern_r <= pattern;
                        expect_r  <= expect_f;
                        len_r     <= len_clamped;
                        idx       <= '0;
                        f_capture <= '0;
                        s_final   <= '0;
                        f_ones    <= '0;
                        pass      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    idx  <= '0;
                    pass <= !abort && (len_r == '0);
                end
                ST_RUN: begin
                    if (abort) begin
                        pass <= 1'b0;
                    end else begin
                        f_capture <= cap_next;
                        if (!last_bit) idx <= idx + LEN_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        pass <= 1'b0;
                    end else begin
                        f_capture <= cap_next;
                        s_final   <= s_in;
                        f_ones    <= ones_next;
                        pass      <= pass_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jk_stim_sequencer.sv
// tb/tb_jk_stim_sequencer.sv - self-checking bench for jk_stim_sequencer
module tb_jk_stim_sequencer;

    localparam int ML = 16;
    localparam int LW = 5;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [ML-1:0] pattern = '0;
    logic [ML-1:0] expect_f = '0;
    logic [LW-1:0] len = '0;
    logic          x_out, m_reset, f_in, busy, done, pass;
    logic [2:0]    s_in, s_final;
    logic [ML-1:0] f_capture;
    logic [LW-1:0] f_ones;

    logic          q_m = 1'b0;
    logic [2:0]    s_m = 3'b000;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (m_reset) begin
            q_m <= 1'b0;
            s_m <= 3'b000;
        end else begin
            q_m <= x_out;
            s_m <= {s_m[1:0], x_out};
        end
    end
    assign f_in = q_m;
    assign s_in = s_m;

    jk_stim_sequencer dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (start),
        .abort     (abort),
        .pattern   (pattern),
        .expect_f  (expect_f),
        .len       (len),
        .x_out     (x_out),
        .m_reset   (m_reset),
        .f_in      (f_in),
        .s_in      (s_in),
        .busy      (busy),
        .done      (done),
        .f_capture (f_capture),
        .s_final   (s_final),
        .f_ones    (f_ones),
        .pass      (pass)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_busy"},  32'(busy), 0);
        check_eq({tag, "_done"},  32'(done), 0);
        check_eq({tag, "_x"},     32'(x_out), 0);
        check_eq({tag, "_mrst"},  32'(m_reset), 0);
        check_eq({tag, "_fcap"},  32'(f_capture), 0);
        check_eq({tag, "_sfin"},  32'(s_final), 0);
        check_eq({tag, "_ones"},  32'(f_ones), 0);
        check_eq({tag, "_pass"},  32'(pass), 0);
    endtask

    // Reference: F after bit k equals x bit k; S holds the last three x bits, newest in bit 0.
    task automatic run_one(input logic [ML-1:0] pat, input logic [ML-1:0] exf, input int ln);
        int            L;
        int            lat;
        int            c;
        bit            seen;
        logic [ML-1:0] mask;
        logic [ML-1:0] efcap;
        logic [2:0]    es;
        L     = (ln > ML) ? ML : ln;
        lat   = (L == 0) ? 2 : L + 3;
        mask  = ML'((32'd1 << L) - 1);
        efcap = pat & mask;
        es    = 3'b000;
        for (int j = 0; j < 3; j++) if (L - 1 - j >= 0) es[j] = pat[L-1-j];
        @(negedge CLK);
        pattern  = pat;
        expect_f = exf;
        len      = LW'(ln);
        start    = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        seen = 1'b0;
        for (c = 1; c <= lat + 2 && !seen; c++) begin
            @(negedge CLK);
            if (c == 1) check_eq("load_mreset", 32'(m_reset), 1);
            if (c >= 2 && c <= L + 1) check_eq("x_seq", 32'(x_out), 32'(pat[c-2]));
            if (done) begin
                seen = 1'b1;
                check_eq("latency", c, lat);
                check_eq("fcap",    32'(f_capture), 32'(efcap));
                check_eq("f_ones",  32'(f_ones), $countones(efcap));
                check_eq("pass",    32'(pass), 32'(((pat ^ exf) & mask) == '0));
                check_eq("s_final", 32'(s_final), 32'(es));
                check_eq("busy_in_done", 32'(busy), 0);
            end
        end
        if (!seen) check_eq("done_timeout", 0, 1);
        @(negedge CLK);
        check_eq("done_one_cycle", 32'(done), 0);
    endtask

    initial begin
        int            done_cnt;
        logic [ML-1:0] p, e;
        int            ln;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_idle_zero("reset");
        RESET = 1'b0;

        run_one(16'h000B, 16'h000B, 4);
        run_one(16'h000B, 16'h0003, 4);
        run_one(16'hA5A5, 16'h0000, 0);
        run_one(16'hBEEF, 16'hBEEF, 20);

        // abort in RUN cycle 2 of len=8, with a start attempted while busy
        @(negedge CLK);
        pattern = 16'h00FF; expect_f = 16'h00FF; len = 5'd8; start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        @(negedge CLK);
        @(negedge CLK); start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        @(negedge CLK);
        check_eq("busy_start_no_reload", 32'(m_reset), 0);
        check_eq("busy_still", 32'(busy), 1);
        @(negedge CLK); abort = 1'b1;
        @(posedge CLK); #1 abort = 1'b0;
        @(negedge CLK);
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_pass", 32'(pass), 0);
        check_eq("abort_x",    32'(x_out), 0);
        done_cnt = 0;
        repeat (12) begin
            @(negedge CLK);
            if (done) done_cnt++;
        end
        check_eq("abort_no_done", done_cnt, 0);

        // reset mid-run
        @(negedge CLK);
        pattern = 16'hFFFF; expect_f = 16'hFFFF; len = 5'd8; start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        repeat (4) @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK); #1 RESET = 1'b0;
        @(negedge CLK);
        check_idle_zero("midrun_reset");
        run_one(16'h0136, 16'h0136, 9);

        for (int it = 0; it < 25; it++) begin
            p  = ML'($urandom);
            ln = $urandom_range(0, 20);
            case ($urandom_range(0, 2))
                0:       e = p;
                1:       e = p ^ ML'(32'd1 << $urandom_range(0, ML - 1));
                default: e = ML'($urandom);
            endcase
            run_one(p, e, ln);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
